// File: rtl/sa1_mmc_addr_pipe_if.sv
// sa1_mmc_addr_pipe_if: requester handshake and translated-result bus for the SA1 MMC address pipe.
interface sa1_mmc_addr_pipe_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 24
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic                     resp_valid;
  logic [1:0]               resp_ch;
  logic [23:0]              ROM_ADDR;
  logic                     ROM_HIT;
  logic                     IS_ROM;
  logic                     IS_SAVERAM;
  logic                     IS_IRAM;
  logic                     IS_REG;
  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_ch, ROM_ADDR, ROM_HIT, IS_ROM, IS_SAVERAM, IS_IRAM, IS_REG
  );
  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_ch, ROM_ADDR, ROM_HIT, IS_ROM, IS_SAVERAM, IS_IRAM, IS_REG
  );
endinterface

// File: rtl/sa1_mmc_addr_pipe.sv
// sa1_mmc_addr_pipe: round-robin arbitrated, two-stage SNES/SA1 address translator with Super MMC banking.
module sa1_mmc_addr_pipe #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 24,
  parameter int BMAP_W = 5
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic [23:0] SAVERAM_MASK,
  input  logic [23:0] ROM_MASK,
  sa1_mmc_addr_pipe_if.slave bus
);
  localparam int CW = 2;
  logic [CW-1:0]     last_q, gch, ch1_q;
  logic              gv, v1_q;
  logic [3:0]        xb_q [4];
  logic [3:0]        xb1_q [4];
  logic [BMAP_W-1:0] sbm_q, cbm_q, sbm1_q, cbm1_q;
  logic [23:0]       a1_q;
  logic              unused_cfg;
  assign unused_cfg = ^cfg_data;
  always_comb begin
    int idx;
    gch = last_q;
    gv = 1'b0;
    idx = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_CH;
      if (bus.req_valid[idx]) begin
        gch = CW'(idx);
        gv = 1'b1;
      end
    end
  end
  assign bus.req_ready = NUM_CH'(gv) << gch;
  // MMC registers keep only the mirror bit and the 3-bit bank
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q <= CW'(NUM_CH - 1);
      xb_q   <= '{4'h0, 4'h1, 4'h2, 4'h3};
      sbm_q  <= '0;
      cbm_q  <= '0;
      v1_q   <= 1'b0;
      a1_q   <= '0;
      ch1_q  <= '0;
      xb1_q  <= '{default: '0};
      sbm1_q <= '0;
      cbm1_q <= '0;
    end else begin
      v1_q <= gv;
      if (gv) begin
        last_q <= gch;
        a1_q   <= 24'(bus.req_addr[int'(gch)*ADDR_W +: ADDR_W]);
        ch1_q  <= gch;
        xb1_q  <= xb_q;
        sbm1_q <= sbm_q;
        cbm1_q <= cbm_q;
      end
      if (cfg_we && !cfg_addr[2]) xb_q[cfg_addr[1:0]] <= {cfg_data[7], cfg_data[2:0]};
      if (cfg_we && cfg_addr == 3'd4) sbm_q <= cfg_data[BMAP_W-1:0];
      if (cfg_we && cfg_addr == 3'd5) cbm_q <= cfg_data[BMAP_W-1:0];
    end
  end
  logic [1:0]        slot;
  logic [3:0]        r;
  logic [2:0]        bank;
  logic [19:0]       off;
  logic [BMAP_W-1:0] bmap;
  logic [23:0]       rom_a, sav_a, addr_d;
  logic              rom, sav, iram, rg, f_iram, f_sav, f_rom;
  always_comb begin
    slot   = a1_q[22] ? a1_q[21:20] : {a1_q[23], a1_q[21]};
    r      = xb1_q[slot];
    bank   = (a1_q[22] || r[3]) ? r[2:0] : {1'b0, slot};
    off    = a1_q[22] ? a1_q[19:0] : {a1_q[20:16], a1_q[14:0]};
    rom_a  = {1'b0, bank, off} & ROM_MASK;
    bmap   = (ch1_q == '0) ? sbm1_q : cbm1_q;
    sav_a  = 24'hE00000 + ((a1_q[22] ? 24'(a1_q[19:0]) : 24'({bmap, a1_q[12:0]})) & SAVERAM_MASK);
    rom    = (~a1_q[22] & a1_q[15]) | (a1_q[23:22] == 2'b11);
    sav    = SAVERAM_MASK[0] & ((a1_q[23:20] == 4'h4) | (~a1_q[22] & ~a1_q[15] & (a1_q[14:13] == 2'b11)));
    iram   = ~a1_q[22] & ((a1_q[15:11] == 5'b00110) | ((ch1_q != '0) & (a1_q[15:11] == 5'b00000)));
    rg     = ~a1_q[22] & (a1_q[15:9] == 7'b0010001);
    f_iram = iram & ~rg;
    f_sav  = sav & ~rg & ~iram;
    f_rom  = rom & ~rg & ~iram & ~sav;
    addr_d = f_sav ? sav_a : f_rom ? rom_a : 24'h0;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.resp_valid <= 1'b0;
      bus.resp_ch    <= '0;
      bus.ROM_ADDR   <= '0;
      bus.ROM_HIT    <= 1'b0;
      bus.IS_ROM     <= 1'b0;
      bus.IS_SAVERAM <= 1'b0;
      bus.IS_IRAM    <= 1'b0;
      bus.IS_REG     <= 1'b0;
    end else begin
      bus.resp_valid <= v1_q;
      if (v1_q) begin
        bus.resp_ch    <= ch1_q;
        bus.ROM_ADDR   <= addr_d;
        bus.ROM_HIT    <= f_rom | f_sav;
        bus.IS_ROM     <= f_rom;
        bus.IS_SAVERAM <= f_sav;
        bus.IS_IRAM    <= f_iram;
        bus.IS_REG     <= rg;
      end
    end
  end
endmodule

// File: doc/sa1_mmc_addr_pipe.md
# sa1_mmc_addr_pipe

Parametrised, pipelined successor to the SA1 address decoder: translates bus addresses from NUM_CH requesters (channel 0 = SNES, channels 1..NUM_CH-1 = SA1 CPU/DMA) into SRAM0 addresses. It adds programmable Super MMC ROM banking (CXB/DXB/EXB/FXB), per-side BW-RAM bitmaps (SBM/CBM), round-robin arbitration and a registered two-stage pipeline. It sits between the SNES/SA1 bus front-ends and the SRAM0 controller.

## Interface
- NUM_CH, 2, number of requesters, 1..4.
- ADDR_W, 24, requester address width.
- BMAP_W, 5, BW-RAM 8 KB block-select width.
- CLK  in  1  system clock, all logic rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config register write strobe.
- cfg_addr  in  3  0..3 = CXB..FXB, 4 = SBM, 5 = CBM, 6..7 ignored.
- cfg_data  in  8  CXB..FXB: bit7 = mirror-enable, bits2:0 = 1 MB bank; SBM/CBM: bits BMAP_W-1:0.
- req_valid  in  NUM_CH  per-channel request.
- req_addr  in  NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_CH  one-hot grant, combinational.
- SAVERAM_MASK, ROM_MASK  in  24 each  static masks from MCU.
- resp_valid  out  1  translated result valid.
- resp_ch  out  2  channel of result.
- ROM_ADDR  out  24  SRAM0 address.
- ROM_HIT, IS_ROM, IS_SAVERAM, IS_IRAM, IS_REG  out  1 each  region flags.

## Operation
- Arbiter: round-robin over req_valid starting at last_grant+1 (mod NUM_CH); at most one req_ready bit per cycle; req_ready[i] only if req_valid[i]. Accept = req_valid & req_ready.
- Stage 1 (on accept): register address, channel, and a snapshot of all six config registers. No accept -> stage-1 valid cleared.
- Stage 2: decode from stage-1 registers only; register all outputs.
- ROM, A = address: IS_ROM = (~A[22] & A[15]) | (A[23:22] == 2'b11).
  - Slot s: LoROM (A[22]=0) s = {A[23], A[21]}; HiROM s = A[21:20]. Slot 0..3 -> CXB..FXB.
  - LoROM: bank = reg[7] ? reg[2:0] : s; offset = {A[20:16], A[14:0]}. HiROM: bank = reg[2:0] always; offset = A[19:0].
  - ROM_ADDR = {1'b0, bank, offset} & ROM_MASK.
- BW-RAM: IS_SAVERAM = SAVERAM_MASK[0] & ((A[23:20] == 4'h4) | (~A[22] & ~A[15] & A[14:13] == 2'b11)).
  - ROM_ADDR = 24'hE00000 + ((A[22] ? A[19:0] : {bmap, A[12:0]}) & SAVERAM_MASK); bmap = SBM for ch 0, CBM otherwise.
- IRAM: ~A[22] and A[15:11] == 5'b00110 (3000-37FF), or channel != 0 and A[15:11] == 0 (0000-07FF). ROM_ADDR = 0.
- IS_REG: ~A[22] and A[15:9] == 7'b0010001 (2200-23FF). ROM_ADDR = 0.
- Priority IS_REG > IS_IRAM > IS_SAVERAM > IS_ROM; exactly one flag set per result, or none.
- ROM_HIT = IS_ROM | IS_SAVERAM.
- Config writes: 8-bit register updated at the cfg_we edge; bits outside each register's width are dropped.

## Timing
- Reset: req pointer last_grant = NUM_CH-1 (first grant goes to ch 0); CXB=0x00, DXB=0x01, EXB=0x02, FXB=0x03; SBM=CBM=0; stage-1 valid=0; resp_valid=0, resp_ch=0, ROM_ADDR=0, all flags 0.
- Latency: accept in cycle N -> result valid in cycle N+2; throughput one result per cycle.
- Config write in cycle N affects requests accepted in N+1 or later. A request accepted in N uses pre-write values, even if it is still in flight.
- Write and accept in the same cycle: request uses old config.
- Reset asserted mid-pipeline: in-flight results are dropped, no resp_valid is produced, and registers return to reset values immediately (async).
- Single requester held valid: granted every cycle. All valid: grants rotate 0,1,...,NUM_CH-1,0.
- No back-pressure on outputs: consumer must sample when resp_valid=1.

## Test plan
- Reset, ch0 requests 00:8000 -> N+2: resp_valid=1, resp_ch=0, IS_ROM=1, ROM_ADDR=0x000000.
- Write CXB=0x85, ch0 requests 00:8000 -> ROM_ADDR=0x500000 (ROM_MASK=FFFFFF). With CXB=0x05 -> ROM_ADDR=0x000000. Request C0:1234 -> ROM_ADDR=0x501234.
- SBM=3, CBM=7, SAVERAM_MASK=03FFFF: ch0 00:6010 -> ROM_ADDR=0xE06010; ch1 00:6010 -> ROM_ADDR=0xE0E010; ch1 41:0005 -> ROM_ADDR=0xE10005.
- ch1 00:0100 -> IS_IRAM=1; ch0 00:0100 -> no flags; ch0 00:2230 -> IS_REG=1.
- Both channels valid for 6 cycles -> grants 0,1,0,1,0,1; resp_ch follows the same order, two cycles later.
- Write FXB in the same cycle as accepting B0:8000 -> old mapping is used; RST_N pulsed while 2 results are in flight -> no resp_valid afterwards.
